// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned ILEN_BYTES = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0033;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instr, pc} entries; flush has priority, push+pop legal when full.
module fetch_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok, w_pop_ok;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rptr];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop_ok) r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns fetch PC, prefetches into a FIFO, handles redirect/halt.
// Optional FETCH_PERF_EN adds push and stall counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter int unsigned        FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic               halted,
  output logic               misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

  fetch_state_e       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_misalign;
  logic               w_full, w_empty, w_pop, w_push, w_aligned;
  logic [ENTRY_W-1:0] w_head;

  assign w_aligned = (redirect_pc[1:0] == 2'b00);
  assign w_pop     = inst_valid && inst_ready;
  // Redirect wins over push; the flushed cycle never captures a word.
  assign w_push    = (r_state == RUN) && !redirect_valid && (!w_full || w_pop);

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  ({imem_data, r_pc}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      if (w_aligned) begin
        r_state    <= RUN;
        r_pc       <= redirect_pc;
        r_misalign <= 1'b0;
      end else begin
        r_state    <= HALT;
        r_misalign <= 1'b1;
      end
    end else begin
      r_misalign <= 1'b0;
      if (w_push) r_pc <= r_pc + ADDR_W'(ILEN_BYTES);
    end
  end

  assign imem_addr    = r_pc;
  assign inst_valid   = !w_empty;
  assign inst         = w_head[ENTRY_W-1 -: INSTR_W];
  assign inst_pc      = w_head[ADDR_W-1:0];
  assign halted       = (r_state == HALT);
  assign misalign_err = r_misalign;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_push) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if ((r_state == RUN) && w_full && !w_pop) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule
